nvram_shadow_ctrl: RTL and testbench

Parametrised non-volatile RAM controller modelling an X2212-style part: a CPU-facing working RAM plus a shadow RAM. A copy engine moves the whole array working→shadow on STORE and shadow→working on RECALL, with a true copy rather than a bank toggle. A host port (MiSTer save/load) reads and writes the shadow array and sees a dirty flag. It replaces the fixed 256×8 nvram in each board's NVRAM wrapper; AW/DW cover other boards' NVRAM sizes.

---
 rtl/nvram_pkg.sv | 15 +
 rtl/dpram_sync.sv | 41 ++++
 rtl/nvram_shadow_ctrl.sv | 121 ++++++++++++
 tb/tb_nvram_shadow_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nvram_pkg.sv
// Shared state encoding and copy-length helper for the NVRAM shadow controller.
package nvram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STORE  = 2'd1,
    RECALL = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  function automatic int unsigned depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/dpram_sync.sv
// True dual-port RAM with synchronous read; dout is registered, 1-cycle latency per port.
// No backpressure: each port accepts one access every cycle; contents are never cleared.
module dpram_sync
  import nvram_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] din_a,
  output logic [DW-1:0] dout_a,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] din_b,
  output logic [DW-1:0] dout_b
);

  localparam int unsigned DEPTH = depth(AW);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
    if (we_b) mem[addr_b] <= din_b;
  end

  // Only the output registers are reset; the array keeps its contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_a <= '0;
      dout_b <= '0;
    end else begin
      dout_a <= mem[addr_a];
      dout_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/nvram_shadow_ctrl.sv
// X2212-style NVRAM: working RAM + shadow RAM with full-array STORE/RECALL copy engine.
// Reads take 1 cycle; a copy is busy for 2^AW+1 cycles, requests while busy are dropped.
module nvram_shadow_ctrl
  import nvram_pkg::*;
#(
  parameter int AW              = 8,
  parameter int DW              = 8,
  parameter bit RECALL_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_ce,
  input  logic          cpu_cs_n,
  input  logic          cpu_rw_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  input  logic          store_req,
  input  logic          recall_req,
  input  logic [AW-1:0] host_addr,
  input  logic          host_we,
  input  logic [DW-1:0] host_din,
  output logic [DW-1:0] host_dout,
  input  logic          host_ack,
  output logic          busy,
  output logic          done,
  output logic          dirty
);

  localparam logic [AW-1:0] LAST = AW'(depth(AW) - 1);

  state_t        state;
  logic [AW-1:0] cnt;
  logic [AW-1:0] wr_addr;
  logic          wr_vld;
  logic          dir_store;
  logic          boot;
  logic [DW-1:0] work_rd;
  logic [DW-1:0] shad_rd;
  logic          store_phase;
  logic          cpu_we;
  logic          host_we_ok;

  // The trailing FLUSH write of a STORE still owns the shadow array.
  assign store_phase = (state == STORE) || ((state == FLUSH) && dir_store);
  assign cpu_we      = cpu_ce & ~cpu_cs_n & ~cpu_rw_n & (state == IDLE);
  assign host_we_ok  = host_we & ~store_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_addr   <= '0;
      wr_vld    <= 1'b0;
      dir_store <= 1'b0;
      boot      <= RECALL_ON_RESET;
      busy      <= 1'b0;
      done      <= 1'b0;
      dirty     <= 1'b0;
    end else begin
      wr_vld  <= (state == STORE) || (state == RECALL);
      wr_addr <= cnt;
      done    <= 1'b0;
      if (host_ack) dirty <= 1'b0;
      case (state)
        IDLE: begin
          if (boot || recall_req) begin
            state     <= RECALL;
            dir_store <= 1'b0;
            busy      <= 1'b1;
            boot      <= 1'b0;
          end else if (store_req) begin
            state     <= STORE;
            dir_store <= 1'b1;
            busy      <= 1'b1;
          end
        end
        STORE, RECALL: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= FLUSH;
            done  <= 1'b1;
          end
        end
        FLUSH: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (dir_store) dirty <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  dpram_sync #(.AW(AW), .DW(DW)) u_work (
    .clk    (clk),
    .reset  (reset),
    .we_a   (cpu_we),
    .addr_a (cpu_addr),
    .din_a  (cpu_din),
    .dout_a (cpu_dout),
    .we_b   (wr_vld & ~dir_store),
    .addr_b (dir_store ? cnt : wr_addr),
    .din_b  (shad_rd),
    .dout_b (work_rd)
  );

  dpram_sync #(.AW(AW), .DW(DW)) u_shadow (
    .clk    (clk),
    .reset  (reset),
    .we_a   (wr_vld & dir_store),
    .addr_a (dir_store ? wr_addr : cnt),
    .din_a  (work_rd),
    .dout_a (shad_rd),
    .we_b   (host_we_ok),
    .addr_b (host_addr),
    .din_b  (host_din),
    .dout_b (host_dout)
  );

endmodule

// File: tb/tb_nvram_shadow_ctrl.sv
// Bench for nvram_shadow_ctrl: AW=8 instance with boot recall, AW=10/DW=16 instance without.
module tb_nvram_shadow_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       cpu_ce, cpu_cs_n, cpu_rw_n;
  logic [7:0] cpu_addr, cpu_din, cpu_dout;
  logic       store_req, recall_req;
  logic [7:0] host_addr, host_din, host_dout;
  logic       host_we, host_ack, busy, done, dirty;

  logic        w_cpu_ce, w_cpu_cs_n, w_cpu_rw_n;
  logic [9:0]  w_cpu_addr, w_host_addr;
  logic [15:0] w_cpu_din, w_cpu_dout, w_host_din, w_host_dout;
  logic        w_store_req, w_recall_req, w_host_we, w_host_ack;
  logic        w_busy, w_done, w_dirty;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  m_work [256];
  logic [7:0]  m_shad [256];
  logic [15:0] w_model [1024];

  localparam int COPY8  = 256 + 1;
  localparam int COPY10 = 1024 + 1;

  nvram_shadow_ctrl #(.AW(8), .DW(8), .RECALL_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset),
    .cpu_ce(cpu_ce), .cpu_cs_n(cpu_cs_n), .cpu_rw_n(cpu_rw_n),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .store_req(store_req), .recall_req(recall_req),
    .host_addr(host_addr), .host_we(host_we), .host_din(host_din), .host_dout(host_dout),
    .host_ack(host_ack), .busy(busy), .done(done), .dirty(dirty)
  );

  nvram_shadow_ctrl #(.AW(10), .DW(16), .RECALL_ON_RESET(1'b0)) dut_w (
    .clk(clk), .reset(reset),
    .cpu_ce(w_cpu_ce), .cpu_cs_n(w_cpu_cs_n), .cpu_rw_n(w_cpu_rw_n),
    .cpu_addr(w_cpu_addr), .cpu_din(w_cpu_din), .cpu_dout(w_cpu_dout),
    .store_req(w_store_req), .recall_req(w_recall_req),
    .host_addr(w_host_addr), .host_we(w_host_we), .host_din(w_host_din), .host_dout(w_host_dout),
    .host_ack(w_host_ack), .busy(w_busy), .done(w_done), .dirty(w_dirty)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    cpu_ce = 1'b1; cpu_cs_n = 1'b0; cpu_rw_n = 1'b0; cpu_addr = a; cpu_din = d;
    tick();
    cpu_ce = 1'b0; cpu_cs_n = 1'b1; cpu_rw_n = 1'b1;
  endtask

  task automatic cpu_read(input logic [7:0] a);
    cpu_cs_n = 1'b0; cpu_rw_n = 1'b1; cpu_addr = a;
    tick();
    cpu_cs_n = 1'b1;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    host_we = 1'b1; host_addr = a; host_din = d;
    tick();
    host_we = 1'b0;
  endtask

  task automatic host_read(input logic [7:0] a);
    host_addr = a;
    tick();
  endtask

  task automatic pulse_ack();
    host_ack = 1'b1;
    tick();
    host_ack = 1'b0;
  endtask

  function automatic void model_store();
    for (int i = 0; i < 256; i++) m_shad[i] = m_work[i];
  endfunction

  function automatic void model_recall();
    for (int i = 0; i < 256; i++) m_work[i] = m_shad[i];
  endfunction

  // Counts busy cycles starting from the current (first busy) cycle; optional host write at cycle host_at.
  task automatic wait_copy(input int host_at, input logic [7:0] ha, input logic [7:0] hd,
                           output int len, output int nd, output logic ld);
    len = 0; nd = 0; ld = 1'b0;
    while (busy && len < 2000) begin
      len++;
      if (done) nd++;
      ld = done;
      host_we = (len == host_at); host_addr = ha; host_din = hd;
      tick();
    end
    host_we = 1'b0;
  endtask

  task automatic test_reset();
    int len, nd;
    logic ld;
    reset = 1'b1;
    repeat (3) tick();
    n_checks++; if (cpu_dout !== 8'h00) $display("FAIL rst_cpu_dout got %0h want 0", cpu_dout); else n_pass++;
    n_checks++; if (host_dout !== 8'h00) $display("FAIL rst_host_dout got %0h want 0", host_dout); else n_pass++;
    n_checks++; if ({busy, done, dirty} !== 3'b000) $display("FAIL rst_flags got %b want 000", {busy, done, dirty}); else n_pass++;
    n_checks++; if ({w_busy, w_done, w_dirty, w_cpu_dout, w_host_dout} !== 35'd0)
      $display("FAIL rst_wide got %b/%h/%h want all 0", {w_busy, w_done, w_dirty}, w_cpu_dout, w_host_dout); else n_pass++;
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL boot_busy_early got %b want 0", busy); else n_pass++;
    tick();
    n_checks++; if (busy !== 1'b1) $display("FAIL boot_busy_rise got %b want 1", busy); else n_pass++;
    wait_copy(0, 8'h00, 8'h00, len, nd, ld);
    n_checks++; if (len !== COPY8) $display("FAIL boot_len got %0d want %0d", len, COPY8); else n_pass++;
    n_checks++; if (nd !== 1 || ld !== 1'b1) $display("FAIL boot_done got %0d/%b want 1/1", nd, ld); else n_pass++;
    n_checks++; if (dirty !== 1'b0) $display("FAIL boot_dirty got %b want 0", dirty); else n_pass++;
    n_checks++; if (w_busy !== 1'b0) $display("FAIL wide_no_boot got %b want 0", w_busy); else n_pass++;
  endtask

  task automatic test_cpu_rw();
    logic [7:0] addrs [16];
    cpu_write(8'h10, 8'hA5); m_work[8'h10] = 8'hA5;
    cpu_write(8'h11, 8'h3C); m_work[8'h11] = 8'h3C;
    cpu_read(8'h10);
    n_checks++; if (cpu_dout !== 8'hA5) $display("FAIL cpu_rd10 got %0h want a5", cpu_dout); else n_pass++;
    cpu_cs_n = 1'b0; cpu_rw_n = 1'b1; cpu_addr = 8'h11;
    #1;
    n_checks++; if (cpu_dout !== 8'hA5) $display("FAIL cpu_latency got %0h want a5", cpu_dout); else n_pass++;
    tick();
    n_checks++; if (cpu_dout !== 8'h3C) $display("FAIL cpu_rd11 got %0h want 3c", cpu_dout); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      addrs[i] = 8'($urandom_range(0, 255));
      m_work[addrs[i]] = 8'($urandom);
      cpu_write(addrs[i], m_work[addrs[i]]);
    end
    for (int i = 0; i < 16; i++) begin
      cpu_read(addrs[i]);
      n_checks++; if (cpu_dout !== m_work[addrs[i]])
        $display("FAIL cpu_rand[%0h] got %0h want %0h", addrs[i], cpu_dout, m_work[addrs[i]]); else n_pass++;
    end
  endtask

  task automatic test_store();
    int len, nd;
    logic ld;
    logic [7:0] a;
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      m_work[i] = a ^ 8'h5A;
      cpu_write(a, a ^ 8'h5A);
    end
    store_req = 1'b1;
    n_checks++; if (busy !== 1'b0) $display("FAIL store_busy_early got %b want 0", busy); else n_pass++;
    tick();
    store_req = 1'b0;
    wait_copy(0, 8'h00, 8'h00, len, nd, ld);
    model_store();
    n_checks++; if (len !== COPY8) $display("FAIL store_len got %0d want %0d", len, COPY8); else n_pass++;
    n_checks++; if (nd !== 1 || ld !== 1'b1) $display("FAIL store_done got %0d/%b want 1/1", nd, ld); else n_pass++;
    n_checks++; if (dirty !== 1'b1) $display("FAIL store_dirty got %b want 1", dirty); else n_pass++;
    host_read(8'hFF);
    n_checks++; if (host_dout !== 8'hA5) $display("FAIL store_hostff got %0h want a5", host_dout); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom_range(0, 255));
      host_read(a);
      n_checks++; if (host_dout !== m_shad[a]) $display("FAIL store_host[%0h] got %0h want %0h", a, host_dout, m_shad[a]); else n_pass++;
    end
    pulse_ack();
    n_checks++; if (dirty !== 1'b0) $display("FAIL ack_dirty got %b want 0", dirty); else n_pass++;
  endtask

  task automatic test_recall();
    int len, nd;
    logic ld;
    logic [7:0] a;
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      m_shad[i] = ~a;
      host_write(a, ~a);
    end
    recall_req = 1'b1;
    tick();
    recall_req = 1'b0;
    wait_copy(0, 8'h00, 8'h00, len, nd, ld);
    model_recall();
    n_checks++; if (len !== COPY8) $display("FAIL recall_len got %0d want %0d", len, COPY8); else n_pass++;
    n_checks++; if (nd !== 1 || ld !== 1'b1) $display("FAIL recall_done got %0d/%b want 1/1", nd, ld); else n_pass++;
    cpu_read(8'h00);
    n_checks++; if (cpu_dout !== 8'hFF) $display("FAIL recall_cpu00 got %0h want ff", cpu_dout); else n_pass++;
    cpu_read(8'h80);
    n_checks++; if (cpu_dout !== 8'h7F) $display("FAIL recall_cpu80 got %0h want 7f", cpu_dout); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom_range(0, 255));
      cpu_read(a);
      n_checks++; if (cpu_dout !== m_work[a]) $display("FAIL recall_cpu[%0h] got %0h want %0h", a, cpu_dout, m_work[a]); else n_pass++;
    end
    n_checks++; if (dirty !== 1'b0) $display("FAIL recall_dirty got %b want 0", dirty); else n_pass++;
  endtask

  task automatic test_random_roundtrip();
    int len, nd;
    logic ld;
    logic [7:0] a;
    for (int i = 0; i < 64; i++) begin
      a = 8'($urandom_range(0, 255));
      m_work[a] = 8'($urandom);
      cpu_write(a, m_work[a]);
    end
    store_req = 1'b1; tick(); store_req = 1'b0;
    wait_copy(0, 8'h00, 8'h00, len, nd, ld);
    model_store();
    n_checks++; if (len !== COPY8) $display("FAIL rt_store_len got %0d want %0d", len, COPY8); else n_pass++;
    for (int i = 0; i < 256; i++) begin
      host_read(8'(i));
      n_checks++; if (host_dout !== m_shad[i]) $display("FAIL rt_host[%0h] got %0h want %0h", i, host_dout, m_shad[i]); else n_pass++;
    end
    for (int i = 0; i < 64; i++) begin
      a = 8'($urandom_range(0, 255));
      m_shad[a] = 8'($urandom);
      host_write(a, m_shad[a]);
    end
    recall_req = 1'b1; tick(); recall_req = 1'b0;
    wait_copy(0, 8'h00, 8'h00, len, nd, ld);
    model_recall();
    n_checks++; if (len !== COPY8) $display("FAIL rt_recall_len got %0d want %0d", len, COPY8); else n_pass++;
    for (int i = 0; i < 256; i++) begin
      cpu_read(8'(i));
      n_checks++; if (cpu_dout !== m_work[i]) $display("FAIL rt_cpu[%0h] got %0h want %0h", i, cpu_dout, m_work[i]); else n_pass++;
    end
    pulse_ack();
  endtask

  task automatic test_drop_and_priority();
    int len, nd;
    logic ld;
    cpu_write(8'h20, 8'hC4); m_work[8'h20] = 8'hC4;
    cpu_write(8'h05, 8'h1E); m_work[8'h05] = 8'h1E;
    store_req = 1'b1; tick(); store_req = 1'b0;
    len = 0; nd = 0;
    while (busy && len < 2000) begin
      len++;
      if (done) nd++;
      cpu_ce = 1'b0; cpu_cs_n = 1'b1; cpu_rw_n = 1'b1; host_we = 1'b0; store_req = 1'b0;
      host_ack = done;
      if (len == 10) begin cpu_ce = 1'b1; cpu_cs_n = 1'b0; cpu_rw_n = 1'b0; cpu_addr = 8'h20; cpu_din = 8'h33; end
      if (len == 30) begin host_we = 1'b1; host_addr = 8'h05; host_din = 8'h77; end
      if (len == 50) store_req = 1'b1;
      tick();
    end
    cpu_ce = 1'b0; cpu_cs_n = 1'b1; cpu_rw_n = 1'b1; host_we = 1'b0; store_req = 1'b0; host_ack = 1'b0;
    model_store();
    n_checks++; if (len !== COPY8) $display("FAIL drop_len got %0d want %0d", len, COPY8); else n_pass++;
    n_checks++; if (nd !== 1) $display("FAIL drop_done_count got %0d want 1", nd); else n_pass++;
    n_checks++; if (dirty !== 1'b1) $display("FAIL set_beats_ack got %b want 1", dirty); else n_pass++;
    repeat (3) tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL req_not_queued busy got %b want 0", busy); else n_pass++;
    cpu_read(8'h20);
    n_checks++; if (cpu_dout !== 8'hC4) $display("FAIL drop_cpu20 got %0h want c4", cpu_dout); else n_pass++;
    host_read(8'h05);
    n_checks++; if (host_dout !== 8'h1E) $display("FAIL drop_host05 got %0h want 1e", host_dout); else n_pass++;
    host_read(8'h20);
    n_checks++; if (host_dout !== 8'hC4) $display("FAIL drop_host20 got %0h want c4", host_dout); else n_pass++;

    cpu_write(8'h40, 8'hED); m_work[8'h40] = 8'hED;
    host_write(8'h40, 8'h12); m_shad[8'h40] = 8'h12;
    store_req = 1'b1; recall_req = 1'b1; tick(); store_req = 1'b0; recall_req = 1'b0;
    wait_copy(5, 8'hF0, 8'h99, len, nd, ld);
    m_shad[8'hF0] = 8'h99;
    model_recall();
    n_checks++; if (len !== COPY8 || nd !== 1) $display("FAIL prio_len got %0d/%0d want %0d/1", len, nd, COPY8); else n_pass++;
    cpu_read(8'h40);
    n_checks++; if (cpu_dout !== m_work[8'h40]) $display("FAIL prio_cpu40 got %0h want %0h", cpu_dout, m_work[8'h40]); else n_pass++;
    cpu_read(8'hF0);
    n_checks++; if (cpu_dout !== m_work[8'hF0]) $display("FAIL recall_hostwr got %0h want %0h", cpu_dout, m_work[8'hF0]); else n_pass++;
    host_read(8'h40);
    n_checks++; if (host_dout !== 8'h12) $display("FAIL prio_host40 got %0h want 12", host_dout); else n_pass++;
    n_checks++; if (dirty !== 1'b1) $display("FAIL prio_dirty got %b want 1", dirty); else n_pass++;
  endtask

  task automatic test_reset_abort();
    int len, nd;
    logic ld;
    host_write(8'h10, 8'h81); m_shad[8'h10] = 8'h81;
    host_write(8'h90, 8'h27); m_shad[8'h90] = 8'h27;
    cpu_write(8'h10, 8'h5C); m_work[8'h10] = 8'h5C;
    cpu_write(8'h90, 8'h6D); m_work[8'h90] = 8'h6D;
    store_req = 1'b1; tick(); store_req = 1'b0;
    nd = 0;
    for (int i = 0; i < 64; i++) begin
      if (done) nd++;
      tick();
    end
    n_checks++; if (busy !== 1'b1) $display("FAIL abort_busy_pre got %b want 1", busy); else n_pass++;
    reset = 1'b1;
    tick();
    for (int i = 0; i < 64; i++) m_shad[i] = m_work[i];
    n_checks++; if ({busy, done, dirty} !== 3'b000 || nd !== 0)
      $display("FAIL abort_flags got %b nd=%0d want 000 nd=0", {busy, done, dirty}, nd); else n_pass++;
    tick();
    reset = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b1) $display("FAIL reboot_busy_rise got %b want 1", busy); else n_pass++;
    wait_copy(0, 8'h00, 8'h00, len, nd, ld);
    model_recall();
    n_checks++; if (len !== COPY8 || nd !== 1) $display("FAIL reboot_len got %0d/%0d want %0d/1", len, nd, COPY8); else n_pass++;
    n_checks++; if (w_busy !== 1'b0) $display("FAIL wide_no_reboot got %b want 0", w_busy); else n_pass++;
    cpu_read(8'h10);
    n_checks++; if (cpu_dout !== m_work[8'h10]) $display("FAIL abort_cpu10 got %0h want %0h", cpu_dout, m_work[8'h10]); else n_pass++;
    cpu_read(8'h90);
    n_checks++; if (cpu_dout !== m_work[8'h90]) $display("FAIL abort_cpu90 got %0h want %0h", cpu_dout, m_work[8'h90]); else n_pass++;
    host_read(8'h90);
    n_checks++; if (host_dout !== 8'h27) $display("FAIL abort_host90 got %0h want 27", host_dout); else n_pass++;
  endtask

  task automatic test_wide();
    int len, nd;
    logic [9:0] wa [8];
    for (int i = 0; i < 8; i++) begin
      wa[i] = 10'($urandom_range(0, 1022));
      w_model[wa[i]] = 16'($urandom);
      w_cpu_ce = 1'b1; w_cpu_cs_n = 1'b0; w_cpu_rw_n = 1'b0; w_cpu_addr = wa[i]; w_cpu_din = w_model[wa[i]];
      tick();
    end
    w_cpu_addr = 10'h3FF; w_cpu_din = 16'hBEEF; w_model[10'h3FF] = 16'hBEEF;
    tick();
    w_cpu_ce = 1'b0; w_cpu_cs_n = 1'b1; w_cpu_rw_n = 1'b1;
    w_store_req = 1'b1; tick(); w_store_req = 1'b0;
    len = 0; nd = 0;
    while (w_busy && len < 4000) begin
      len++;
      if (w_done) nd++;
      tick();
    end
    n_checks++; if (len !== COPY10 || nd !== 1) $display("FAIL wide_len got %0d/%0d want %0d/1", len, nd, COPY10); else n_pass++;
    n_checks++; if (w_dirty !== 1'b1) $display("FAIL wide_dirty got %b want 1", w_dirty); else n_pass++;
    w_host_addr = 10'h3FF; tick();
    n_checks++; if (w_host_dout !== 16'hBEEF) $display("FAIL wide_host3ff got %0h want beef", w_host_dout); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      w_host_addr = wa[i]; tick();
      n_checks++; if (w_host_dout !== w_model[wa[i]])
        $display("FAIL wide_host[%0h] got %0h want %0h", wa[i], w_host_dout, w_model[wa[i]]); else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1;
    cpu_ce = 1'b0; cpu_cs_n = 1'b1; cpu_rw_n = 1'b1; cpu_addr = '0; cpu_din = '0;
    store_req = 1'b0; recall_req = 1'b0;
    host_addr = '0; host_din = '0; host_we = 1'b0; host_ack = 1'b0;
    w_cpu_ce = 1'b0; w_cpu_cs_n = 1'b1; w_cpu_rw_n = 1'b1; w_cpu_addr = '0; w_cpu_din = '0;
    w_store_req = 1'b0; w_recall_req = 1'b0;
    w_host_addr = '0; w_host_din = '0; w_host_we = 1'b0; w_host_ack = 1'b0;
    test_reset();
    test_cpu_rw();
    test_store();
    test_recall();
    test_random_roundtrip();
    test_drop_and_priority();
    test_reset_abort();
    test_wide();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
